// File: rtl/proc_sched_timers_pkg.sv
// proc_sched_timers_pkg: shared constants for proc_sched_timers
//   ctrl bit positions, command field offsets/widths and timer mode encodings.
package proc_sched_timers_pkg;
  localparam int CTRL_RST_TKR = 0;
  localparam int CTRL_SET_PER = 1;
  localparam int CTRL_BIND    = 2;
  localparam int CTRL_CLR     = 3;
  localparam int CTRL_EN      = 4;
  localparam int CTRL_DIS     = 5;
  localparam int CTRL_FRC     = 6;
  localparam int CTRL_MODE    = 7;
  localparam int CTRL_OFS     = 0;
  localparam int CTRL_W       = 8;
  localparam int INDEX_OFS    = 8;
  localparam int INDEX_W      = 4;
  localparam int OPND_OFS     = 16;
  localparam int OPND_W       = 16;
  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;
endpackage

// File: rtl/proc_sched_tim.sv
// proc_sched_tim: one process timer bound to a shared ticker
//   clk, rst_n   : clock, synchronous active-low reset
//   sel          : a command strobe addressed to this timer
//   ctrl         : command ctrl bits
//   tkr_op       : operand[3:0] (ticker number for bind, bit 0 = mode)
//   done_vec     : period_done of all tickers, zero-padded to 16
//   ready, ovr   : registered ready flag and sticky overrun flag
// Overrun tracking exists only with PROC_SCHED_TIMERS_OVERRUN_EN defined.
module proc_sched_tim
  import proc_sched_timers_pkg::*;
#(
  parameter int NUM_TICKERS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [7:0]  ctrl,
  input  logic [3:0]  tkr_op,
  input  logic [15:0] done_vec,
  output logic        ready,
  output logic        ovr
);
  logic [3:0] tkr;
  logic       en;
  mode_e      mode;
  logic       done;
  logic       bind_ok;
  logic       cmd;
  assign done    = done_vec[tkr];
  // a bind naming a nonexistent ticker is treated as absent
  assign bind_ok = ctrl[CTRL_BIND] & (32'(tkr_op) < NUM_TICKERS);
  // any state-changing command for this timer masks a same-cycle period_done
  assign cmd     = sel & (ctrl[CTRL_DIS] | bind_ok | ctrl[CTRL_EN] | ctrl[CTRL_CLR] | ctrl[CTRL_FRC]);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tkr   <= '0;
      en    <= 1'b0;
      mode  <= MODE_PERIODIC;
      ready <= 1'b0;
    end else begin
      if (sel & ctrl[CTRL_MODE]) mode <= mode_e'(tkr_op[0]);
      if (cmd) begin
        if (ctrl[CTRL_DIS]) begin
          en    <= 1'b0;
          ready <= 1'b0;
        end else if (bind_ok) begin
          tkr   <= tkr_op;
          en    <= 1'b1;
          ready <= 1'b0;
        end else if (ctrl[CTRL_EN]) begin
          en    <= 1'b1;
          ready <= 1'b0;
        end else if (ctrl[CTRL_CLR]) begin
          ready <= 1'b0;
        end else if (en) begin
          ready <= 1'b1;
        end
      end else if (done & en) begin
        ready <= 1'b1;
        if (mode == MODE_ONESHOT) en <= 1'b0;
      end
    end
  end
`ifdef PROC_SCHED_TIMERS_OVERRUN_EN
  logic ovr_clr;
  logic ovr_set;
  assign ovr_clr = cmd & ~ctrl[CTRL_DIS] & (bind_ok | (~ctrl[CTRL_EN] & ctrl[CTRL_CLR]));
  assign ovr_set = ~cmd & done & en & ready;
  always_ff @(posedge clk) begin
    if (!rst_n || ovr_clr) ovr <= 1'b0;
    else if (ovr_set) ovr <= 1'b1;
  end
`else
  assign ovr = 1'b0;
`endif
endmodule

// File: rtl/proc_sched_timers.sv
// proc_sched_timers: shared tickers driving a bank of process timers
//   clk, rst_n : clock, synchronous active-low reset
//   wr, tick   : command strobe, timebase pulse
//   data_in    : [7:0] ctrl, [11:8] index, [31:16] operand
//   data_out   : [31:16] overrun vector, [15:0] ready vector
//   procRdy    : per-timer ready flags
// Define PROC_SCHED_TIMERS_OVERRUN_EN to enable sticky overrun flags.
module proc_sched_timers
  import proc_sched_timers_pkg::*;
#(
  parameter int NUM_TICKERS = 8,
  parameter int TICKER_W    = 16,
  parameter int NUM_PTMR    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr,
  input  logic                tick,
  input  logic [31:0]         data_in,
  output logic [31:0]         data_out,
  output logic [NUM_PTMR-1:0] procRdy
);
  logic [CTRL_W-1:0]      ctrl;
  logic [INDEX_W-1:0]     idx;
  logic [OPND_W-1:0]      operand;
  logic [NUM_TICKERS-1:0] done;
  logic [15:0]            done_vec;
  logic [NUM_PTMR-1:0]    ovr;
  logic                   unused_bits;
  assign ctrl        = data_in[CTRL_OFS +: CTRL_W];
  assign idx         = data_in[INDEX_OFS +: INDEX_W];
  assign operand     = data_in[OPND_OFS +: OPND_W];
  assign done_vec    = 16'(done);
  assign unused_bits = ^{data_in[15:12], operand};
  for (genvar k = 0; k < NUM_TICKERS; k++) begin : g_tkr
    logic [TICKER_W-1:0] period;
    logic [TICKER_W-1:0] count;
    assign done[k] = tick & (count == period) & (period != '0);
    // a period written below the running count lets the count run on and wrap
    always_ff @(posedge clk) begin
      if (!rst_n) period <= '0;
      else if (wr & ctrl[CTRL_SET_PER] & (idx == 4'(k))) period <= operand[TICKER_W-1:0];
      if (!rst_n || (wr & ctrl[CTRL_RST_TKR]) || done[k] || period == '0) count <= '0;
      else count <= count + TICKER_W'(tick);
    end
  end
  for (genvar i = 0; i < NUM_PTMR; i++) begin : g_tim
    proc_sched_tim #(.NUM_TICKERS(NUM_TICKERS)) u_tim (
      .clk      (clk),
      .rst_n    (rst_n),
      .sel      (wr & (idx == 4'(i))),
      .ctrl     (ctrl),
      .tkr_op   (operand[3:0]),
      .done_vec (done_vec),
      .ready    (procRdy[i]),
      .ovr      (ovr[i])
    );
  end
  assign data_out = {16'(ovr), 16'(procRdy)};
endmodule
